tinyml_cam_awb_stats: RTL and testbench
=======================================

Name: tinyml_cam_awb_stats

Overview:
- Auto-white-balance controller for the 4PPC Bayer camera path.
- Sits directly downstream of the RGB gain stage and consumes its output stream. Per frame it accumulates R, G and B sums, then closes the loop by driving the 3-bit red/green/blue gain inputs of that gain stage.
- Each complete frame updates the red and blue gains by at most one code step. Step size is set by a hysteresis band.

Parameters:
- P_DEPTH, 10, bits per pixel.
- PW, P_DEPTH*4, data bus width (4 pixels per clock).
- FRAME_WIDTH, 640, pixels per line (multiple of 4).
- FRAME_HEIGHT, 480, lines per frame.
- ACC_W, P_DEPTH+$clog2(FRAME_WIDTH*FRAME_HEIGHT/2), accumulator width (holds the G sum without overflow).

Ports:
- i_pclk  in  1  pixel clock.
- i_arstn  in  1  asynchronous active-low reset.
- i_vs  in  1  vsync; falling edge marks start of frame.
- i_valid  in  1  data beat valid.
- i_data  in  PW  4 Bayer pixels; pix3 = [PW-1:3*P_DEPTH] … pix0 = [P_DEPTH-1:0].
- i_awb_en  in  1  1 = automatic gains, 0 = manual gains.
- i_red_gain_man  in  3  manual red gain code.
- i_blue_gain_man  in  3  manual blue gain code.
- o_red_gain  out  3  red gain code to the gain stage.
- o_green_gain  out  3  green gain code; constant 3'b100 (x1.0).
- o_blue_gain  out  3  blue gain code to the gain stage.
- o_stat_valid  out  1  one-cycle pulse when statistics have been evaluated.
- o_frame_err  out  1  one-cycle pulse when the previous frame was incomplete.

Behaviour:
- Reset (async assert, sync release):
  - o_red_gain = o_blue_gain = 3'b100; o_green_gain = 3'b100.
  - o_stat_valid = 0, o_frame_err = 0.
  - All accumulators, counters and snapshots = 0; FSM = IDLE.
- Frame start event (FS): registered i_vs = 1 and current i_vs = 0.
- Beat counter:
  - Counts valid beats modulo FRAME_WIDTH/4.
  - At the last beat of a line it wraps to 0, toggles line parity and increments the line count.
  - FS clears the beat counter, parity and line count.
- Bayer layout:
  - Parity 0 (first line of frame): pix3 = G, pix2 = R, pix1 = G, pix0 = R.
  - Parity 1: pix3 = B, pix2 = G, pix1 = B, pix0 = G.
- Accumulation, per valid beat:
  - Parity 0: R_acc += pix2 + pix0; G_acc += pix3 + pix1.
  - Parity 1: B_acc += pix3 + pix1; G_acc += pix2 + pix0.
  - Unsigned arithmetic at ACC_W bits.
  - Line count saturates at FRAME_HEIGHT+1; accumulators are not saturated (sized for a nominal frame).
- On FS:
  - Copy R_acc, G_acc, B_acc and (line count == FRAME_HEIGHT) into snapshot registers.
  - Clear the accumulators.
  - If i_valid is high in the FS cycle, that beat is the first beat of the new frame: the accumulators load the beat value instead of clearing to 0.
- FSM states: IDLE, CMP, UPDATE.
  - IDLE -> CMP on FS (snapshot loaded at the same edge).
  - CMP: T = G_snap >> 1; TH = T >> 3.
    - Register lo_r = R_snap < T - TH; hi_r = R_snap > T + TH.
    - Register lo_b and hi_b the same way from B_snap.
    - Go to UPDATE.
  - UPDATE: pulse o_stat_valid; return to IDLE.
    - Snapshot incomplete: pulse o_frame_err instead; gains unchanged.
    - Otherwise, and if i_awb_en = 1:
      - lo: gain code +1, saturating at 7.
      - hi: gain code −1, saturating at 1 (code 0 = zero gain, never produced).
      - Neither: hold.
- Latency: the FS cycle is cycle N. Snapshot is loaded at edge N+1, flags at N+2, gains and pulses at N+3.
- FS while in CMP or UPDATE: the snapshot is reloaded and the FSM restarts at CMP. The in-flight evaluation is dropped with no pulse.
- i_awb_en = 0:
  - o_red_gain and o_blue_gain follow the manual inputs with 1 register of latency.
  - Statistics still run and o_stat_valid still pulses.
- i_awb_en 0 -> 1: automatic stepping starts from the current manual codes.
- Reset mid-frame: everything returns to reset values. The first FS after reset is evaluated normally; that frame is incomplete, so o_frame_err pulses.

Test Plan:
- Use FRAME_WIDTH = 8, FRAME_HEIGHT = 4, P_DEPTH = 10: 2 beats per line, 8 R, 16 G and 8 B pixels per frame.
- Flat frame, all pixels 512, then FS:
  - Expect R_snap = 4096, G_snap = 8192, T = 4096.
  - 3 cycles after FS: o_stat_valid pulses; gains stay 100/100/100.
- R pixels 256, G and B 512:
  - R_snap = 2048 < 3584, so o_red_gain -> 101; o_blue_gain stays 100.
- B pixels 1023, G 512, R 512:
  - B_snap = 8184 > 4608, so o_blue_gain 100 -> 011.
  - Repeat for 4 such frames: o_blue_gain steps to 010, then 001, then holds at 001.
- Frame with only 3 lines before FS:
  - o_frame_err pulses at N+3, o_stat_valid stays 0, gains unchanged.
- Saturation and manual override:
  - R pixels 0 for 5 frames: o_red_gain steps 100 -> 111 and holds at 111.
  - Then i_awb_en = 0 with i_red_gain_man = 010: o_red_gain = 010 one cycle later.
- Edge cases:
  - i_valid high with pix = 1023 in the FS cycle: the new frame's R_acc starts at 2046 (pix2 + pix0).
  - Reset asserted mid-frame: all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tinyml_cam_awb_stats.sv
// ---------------------------------------------------------------------------------------------
// tinyml_cam_awb_stats
//
// Auto-white-balance loop for the 4-pixel-per-clock Bayer camera path. It observes the output of
// the RGB gain stage, accumulates per-frame R, G and B sums, and at every frame start compares
// the red and blue sums against half the green sum. Red and blue gain codes then move by at most
// one step per frame. A +/-1/8 hysteresis band around the target stops the loop from dithering.
//
// Ports
//   i_pclk           pixel clock
//   i_arstn          asynchronous active-low reset (release is synchronous to i_pclk upstream)
//   i_vs             vsync; a falling edge marks frame start
//   i_valid          data beat valid
//   i_data           four Bayer pixels, pix3 in the top P_DEPTH bits, pix0 in the bottom
//   i_awb_en         1 = automatic gains, 0 = gains follow the manual inputs
//   i_red_gain_man   manual red gain code
//   i_blue_gain_man  manual blue gain code
//   o_red_gain       red gain code to the gain stage
//   o_green_gain     green gain code, fixed at unity (3'b100)
//   o_blue_gain      blue gain code to the gain stage
//   o_stat_valid     one-cycle pulse after a complete frame has been evaluated
//   o_frame_err      one-cycle pulse, in place of o_stat_valid, when the frame was incomplete
// ---------------------------------------------------------------------------------------------
module tinyml_cam_awb_stats #(
    parameter int unsigned P_DEPTH      = 10,
    parameter int unsigned PW           = P_DEPTH * 4,
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned ACC_W        = P_DEPTH + $clog2(FRAME_WIDTH * FRAME_HEIGHT / 2)
) (
    input  logic          i_pclk,
    input  logic          i_arstn,
    input  logic          i_vs,
    input  logic          i_valid,
    input  logic [PW-1:0] i_data,
    input  logic          i_awb_en,
    input  logic [2:0]    i_red_gain_man,
    input  logic [2:0]    i_blue_gain_man,
    output logic [2:0]    o_red_gain,
    output logic [2:0]    o_green_gain,
    output logic [2:0]    o_blue_gain,
    output logic          o_stat_valid,
    output logic          o_frame_err
);

    // -----------------------------------------------------------------------------------------
    // Geometry
    // -----------------------------------------------------------------------------------------
    localparam int unsigned BEATS    = FRAME_WIDTH / 4;
    localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LINE_MAX = FRAME_HEIGHT + 1;
    localparam int unsigned LINE_W   = $clog2(FRAME_HEIGHT + 2);

    localparam logic [2:0] GAIN_UNITY = 3'b100;
    localparam logic [2:0] GAIN_MAX   = 3'd7;
    localparam logic [2:0] GAIN_MIN   = 3'd1;

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StUpdate
    } state_e;

    // -----------------------------------------------------------------------------------------
    // Frame start detection
    // -----------------------------------------------------------------------------------------
    logic vs_q;
    logic fs;

    assign fs = vs_q & ~i_vs;

    always_ff @(posedge i_pclk or negedge i_arstn) begin
        if (!i_arstn) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= i_vs;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Pixel unpacking: pairs that always share a colour within a line
    // -----------------------------------------------------------------------------------------
    logic [P_DEPTH-1:0] pix0, pix1, pix2, pix3;
    logic [ACC_W-1:0]   sum_even;  // pix2 + pix0
    logic [ACC_W-1:0]   sum_odd;   // pix3 + pix1

    assign pix0     = i_data[P_DEPTH-1:0];
    assign pix1     = i_data[2*P_DEPTH-1:P_DEPTH];
    assign pix2     = i_data[3*P_DEPTH-1:2*P_DEPTH];
    assign pix3     = i_data[4*P_DEPTH-1:3*P_DEPTH];
    assign sum_even = ACC_W'(pix2) + ACC_W'(pix0);
    assign sum_odd  = ACC_W'(pix3) + ACC_W'(pix1);

    // -----------------------------------------------------------------------------------------
    // Beat / line position and colour accumulators
    // -----------------------------------------------------------------------------------------
    logic [BEAT_W-1:0] beat_q, beat_d, beat_cur;
    logic              par_q, par_d, par_cur;
    logic [LINE_W-1:0] line_q, line_d, line_cur;
    logic [ACC_W-1:0]  r_acc_q, r_acc_d, r_base;
    logic [ACC_W-1:0]  g_acc_q, g_acc_d, g_base;
    logic [ACC_W-1:0]  b_acc_q, b_acc_d, b_base;

    always_comb begin
        // A beat that arrives in the FS cycle is the first beat of the new frame, so it is
        // placed at position zero and added onto cleared accumulators.
        beat_cur = fs ? '0 : beat_q;
        par_cur  = fs ? 1'b0 : par_q;
        line_cur = fs ? '0 : line_q;
        r_base   = fs ? '0 : r_acc_q;
        g_base   = fs ? '0 : g_acc_q;
        b_base   = fs ? '0 : b_acc_q;

        beat_d  = beat_cur;
        par_d   = par_cur;
        line_d  = line_cur;
        r_acc_d = r_base;
        g_acc_d = g_base;
        b_acc_d = b_base;

        if (i_valid) begin
            if (beat_cur == BEAT_W'(BEATS - 1)) begin
                beat_d = '0;
                par_d  = ~par_cur;
                // Saturating one past a full frame keeps overlong frames distinguishable.
                if (line_cur != LINE_W'(LINE_MAX)) begin
                    line_d = line_cur + 1'b1;
                end
            end else begin
                beat_d = beat_cur + 1'b1;
            end

            if (!par_cur) begin
                // G R G R line
                r_acc_d = r_base + sum_even;
                g_acc_d = g_base + sum_odd;
            end else begin
                // B G B G line
                b_acc_d = b_base + sum_odd;
                g_acc_d = g_base + sum_even;
            end
        end
    end

    always_ff @(posedge i_pclk or negedge i_arstn) begin
        if (!i_arstn) begin
            beat_q  <= '0;
            par_q   <= 1'b0;
            line_q  <= '0;
            r_acc_q <= '0;
            g_acc_q <= '0;
            b_acc_q <= '0;
        end else begin
            beat_q  <= beat_d;
            par_q   <= par_d;
            line_q  <= line_d;
            r_acc_q <= r_acc_d;
            g_acc_q <= g_acc_d;
            b_acc_q <= b_acc_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Snapshot of the finished frame, taken at frame start
    // -----------------------------------------------------------------------------------------
    logic [ACC_W-1:0] r_snap_q, g_snap_q, b_snap_q;
    logic             complete_q;

    always_ff @(posedge i_pclk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_snap_q   <= '0;
            g_snap_q   <= '0;
            b_snap_q   <= '0;
            complete_q <= 1'b0;
        end else if (fs) begin
            r_snap_q   <= r_acc_q;
            g_snap_q   <= g_acc_q;
            b_snap_q   <= b_acc_q;
            complete_q <= (line_q == LINE_W'(FRAME_HEIGHT));
        end
    end

    // -----------------------------------------------------------------------------------------
    // Hysteresis band: target is half the green sum (twice as many G pixels as R or B)
    // -----------------------------------------------------------------------------------------
    logic [ACC_W-1:0] t_val, th_val, lo_thr, hi_thr;

    always_comb begin
        t_val  = g_snap_q >> 1;
        th_val = t_val >> 3;
        lo_thr = t_val - th_val;
        hi_thr = t_val + th_val;
    end

    // One code step toward the target, never reaching code 0 (zero gain) automatically.
    function automatic logic [2:0] step_gain(input logic [2:0] gain,
                                             input logic       lo,
                                             input logic       hi);
        logic [2:0] res;
        res = gain;
        if (lo && (gain != GAIN_MAX)) begin
            res = gain + 3'd1;
        end else if (hi && (gain > GAIN_MIN)) begin
            res = gain - 3'd1;
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------------------------
    // Evaluation FSM with registered gains and pulses
    // -----------------------------------------------------------------------------------------
    state_e     state_q;
    logic       lo_r_q, hi_r_q, lo_b_q, hi_b_q;
    logic [2:0] red_q, blue_q;
    logic       stat_valid_q, frame_err_q;

    always_ff @(posedge i_pclk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q      <= StIdle;
            lo_r_q       <= 1'b0;
            hi_r_q       <= 1'b0;
            lo_b_q       <= 1'b0;
            hi_b_q       <= 1'b0;
            red_q        <= GAIN_UNITY;
            blue_q       <= GAIN_UNITY;
            stat_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            stat_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            // Manual mode tracks the inputs every cycle; the automatic loop then resumes from
            // whatever codes were last applied.
            if (!i_awb_en) begin
                red_q  <= i_red_gain_man;
                blue_q <= i_blue_gain_man;
            end

            if (fs) begin
                // New snapshot arrives at this edge; any evaluation in flight is abandoned.
                state_q <= StCmp;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StIdle;
                    end
                    StCmp: begin
                        lo_r_q  <= (r_snap_q < lo_thr);
                        hi_r_q  <= (r_snap_q > hi_thr);
                        lo_b_q  <= (b_snap_q < lo_thr);
                        hi_b_q  <= (b_snap_q > hi_thr);
                        state_q <= StUpdate;
                    end
                    StUpdate: begin
                        state_q <= StIdle;
                        if (!complete_q) begin
                            frame_err_q <= 1'b1;
                        end else begin
                            stat_valid_q <= 1'b1;
                            if (i_awb_en) begin
                                red_q  <= step_gain(red_q, lo_r_q, hi_r_q);
                                blue_q <= step_gain(blue_q, lo_b_q, hi_b_q);
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign o_red_gain   = red_q;
    assign o_green_gain = GAIN_UNITY;
    assign o_blue_gain  = blue_q;
    assign o_stat_valid = stat_valid_q;
    assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_tinyml_cam_awb_stats.sv
// ---------------------------------------------------------------------------------------------
// tb_tinyml_cam_awb_stats
//
// Bench for tinyml_cam_awb_stats with an 8x4 frame (2 beats per line). A table of frames with
// hand-derived gain results drives the main loop; every frame start pushes the expected pulse
// (cycle, kind, gains) to a scoreboard that a monitor pops when the DUT pulses. Hand-written
// sequences cover manual override, FS during evaluation, a beat in the FS cycle, and reset
// asserted mid-frame.
// ---------------------------------------------------------------------------------------------
module tb_tinyml_cam_awb_stats;

    localparam int unsigned PD = 10;
    localparam int unsigned FW = 8;
    localparam int unsigned FH = 4;

    logic          i_pclk;
    logic          i_arstn;
    logic          i_vs;
    logic          i_valid;
    logic [4*PD-1:0] i_data;
    logic          i_awb_en;
    logic [2:0]    i_red_gain_man;
    logic [2:0]    i_blue_gain_man;
    logic [2:0]    o_red_gain;
    logic [2:0]    o_green_gain;
    logic [2:0]    o_blue_gain;
    logic          o_stat_valid;
    logic          o_frame_err;

    tinyml_cam_awb_stats #(
        .P_DEPTH      (PD),
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH)
    ) dut (
        .i_pclk          (i_pclk),
        .i_arstn         (i_arstn),
        .i_vs            (i_vs),
        .i_valid         (i_valid),
        .i_data          (i_data),
        .i_awb_en        (i_awb_en),
        .i_red_gain_man  (i_red_gain_man),
        .i_blue_gain_man (i_blue_gain_man),
        .o_red_gain      (o_red_gain),
        .o_green_gain    (o_green_gain),
        .o_blue_gain     (o_blue_gain),
        .o_stat_valid    (o_stat_valid),
        .o_frame_err     (o_frame_err)
    );

    initial begin
        i_pclk = 1'b0;
        forever #5 i_pclk = ~i_pclk;
    end

    int cyc;
    always @(posedge i_pclk) cyc <= cyc + 1;

    int n_checks;
    int n_fails;

    typedef struct {
        int         cyc;
        bit         err;
        logic [2:0] red;
        logic [2:0] blue;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        int         r;
        int         g;
        int         b;
        int         lines;
        bit         awb;
        logic [2:0] rman;
        logic [2:0] bman;
        bit         err;
        logic [2:0] red;
        logic [2:0] blue;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pops the scoreboard on the due cycle; any pulse outside an expected slot is an error.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge i_pclk);
            if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("stat_valid", 32'(o_stat_valid), 32'(!e.err));
                check("frame_err", 32'(o_frame_err), 32'(e.err));
                check("red_gain", 32'(o_red_gain), 32'(e.red));
                check("blue_gain", 32'(o_blue_gain), 32'(e.blue));
                check("green_gain", 32'(o_green_gain), 32'd4);
            end else if (o_stat_valid || o_frame_err) begin
                check("unexpected_pulse", 32'({o_stat_valid, o_frame_err}), 32'd0);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_pclk);
            #1;
            i_valid = 1'b0;
        end
    endtask

    task automatic send_beat(input int p3, input int p2, input int p1, input int p0);
        @(posedge i_pclk);
        #1;
        i_valid = 1'b1;
        i_data  = {PD'(p3), PD'(p2), PD'(p1), PD'(p0)};
    endtask

    task automatic drive_frame(input int r, input int g, input int b, input int lines);
        for (int l = 0; l < lines; l++) begin
            for (int k = 0; k < FW / 4; k++) begin
                if (l % 2 == 0) send_beat(g, r, g, r);
                else            send_beat(b, g, b, g);
            end
        end
    endtask

    // vsync high for one cycle, then low: the low cycle is the FS cycle. Optionally a beat of
    // all-1023 pixels rides in the FS cycle.
    task automatic do_fs(input bit beat, input bit err, input logic [2:0] red,
                         input logic [2:0] blue);
        exp_t e;
        @(posedge i_pclk);
        #1;
        i_valid = 1'b0;
        i_vs    = 1'b1;
        @(posedge i_pclk);
        #1;
        i_vs    = 1'b0;
        i_valid = beat;
        if (beat) i_data = {PD'(1023), PD'(1023), PD'(1023), PD'(1023)};
        e.cyc  = cyc + 3;
        e.err  = err;
        e.red  = red;
        e.blue = blue;
        sb.push_back(e);
    endtask

    initial begin
        n_checks        = 0;
        n_fails         = 0;
        i_arstn         = 1'b0;
        i_vs            = 1'b0;
        i_valid         = 1'b0;
        i_data          = '0;
        i_awb_en        = 1'b1;
        i_red_gain_man  = 3'd4;
        i_blue_gain_man = 3'd4;

        //            r    g    b    ln awb rman  bman  err red   blue
        vecs[0]  = '{512, 512, 512,  4, 1, 3'd4, 3'd4, 0, 3'd4, 3'd4};
        vecs[1]  = '{256, 512, 512,  4, 1, 3'd4, 3'd4, 0, 3'd5, 3'd4};
        vecs[2]  = '{512, 512, 1023, 4, 1, 3'd4, 3'd4, 0, 3'd5, 3'd3};
        vecs[3]  = '{512, 512, 1023, 4, 1, 3'd4, 3'd4, 0, 3'd5, 3'd2};
        vecs[4]  = '{512, 512, 1023, 4, 1, 3'd4, 3'd4, 0, 3'd5, 3'd1};
        vecs[5]  = '{512, 512, 1023, 4, 1, 3'd4, 3'd4, 0, 3'd5, 3'd1};
        vecs[6]  = '{512, 512, 512,  3, 1, 3'd4, 3'd4, 1, 3'd5, 3'd1};
        vecs[7]  = '{512, 512, 512,  4, 0, 3'd4, 3'd4, 0, 3'd4, 3'd4};
        vecs[8]  = '{0,   512, 512,  4, 1, 3'd4, 3'd4, 0, 3'd5, 3'd4};
        vecs[9]  = '{0,   512, 512,  4, 1, 3'd4, 3'd4, 0, 3'd6, 3'd4};
        vecs[10] = '{0,   512, 512,  4, 1, 3'd4, 3'd4, 0, 3'd7, 3'd4};
        vecs[11] = '{0,   512, 512,  4, 1, 3'd4, 3'd4, 0, 3'd7, 3'd4};
        vecs[12] = '{0,   512, 512,  4, 1, 3'd4, 3'd4, 0, 3'd7, 3'd4};

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge i_pclk);
        @(negedge i_pclk);
        check("rst_red", 32'(o_red_gain), 32'd4);
        check("rst_green", 32'(o_green_gain), 32'd4);
        check("rst_blue", 32'(o_blue_gain), 32'd4);
        check("rst_stat_valid", 32'(o_stat_valid), 32'd0);
        check("rst_frame_err", 32'(o_frame_err), 32'd0);
        i_arstn = 1'b1;
        idle(2);

        // First FS after reset: nothing accumulated, so the frame is incomplete
        do_fs(1'b0, 1'b1, 3'd4, 3'd4);
        idle(6);

        for (int v = 0; v < 13; v++) begin
            i_awb_en        = vecs[v].awb;
            i_red_gain_man  = vecs[v].rman;
            i_blue_gain_man = vecs[v].bman;
            idle(1);
            drive_frame(vecs[v].r, vecs[v].g, vecs[v].b, vecs[v].lines);
            do_fs(1'b0, vecs[v].err, vecs[v].red, vecs[v].blue);
            idle(6);
        end

        // Manual override: one register of latency
        @(posedge i_pclk);
        #1;
        i_awb_en        = 1'b0;
        i_red_gain_man  = 3'd2;
        i_blue_gain_man = 3'd5;
        @(negedge i_pclk);
        check("man_red_before", 32'(o_red_gain), 32'd7);
        check("man_blue_before", 32'(o_blue_gain), 32'd4);
        @(posedge i_pclk);
        #1;
        check("man_red_after", 32'(o_red_gain), 32'd2);
        check("man_blue_after", 32'(o_blue_gain), 32'd5);
        i_awb_en = 1'b1;
        idle(2);

        // FS during UPDATE: first evaluation dropped, only the restarted one pulses
        @(posedge i_pclk);
        #1;
        i_vs = 1'b1;
        @(posedge i_pclk);
        #1;
        i_vs = 1'b0;
        do_fs(1'b0, 1'b1, 3'd2, 3'd5);
        idle(6);

        // Beat in the FS cycle counts as the first beat of the new frame.
        // R = 2046 + 6*400 = 4446, G = 2046 + 14*512 = 9214, B = 4096; band [4032, 5182].
        do_fs(1'b1, 1'b1, 3'd2, 3'd5);
        send_beat(512, 400, 512, 400);
        send_beat(512, 512, 512, 512);
        send_beat(512, 512, 512, 512);
        send_beat(512, 400, 512, 400);
        send_beat(512, 400, 512, 400);
        send_beat(512, 512, 512, 512);
        send_beat(512, 512, 512, 512);
        do_fs(1'b0, 1'b0, 3'd2, 3'd5);
        idle(6);

        // Reset mid-frame: outputs return to reset values without a clock edge
        send_beat(512, 256, 512, 256);
        send_beat(512, 256, 512, 256);
        send_beat(512, 512, 512, 512);
        @(posedge i_pclk);
        #3;
        i_arstn = 1'b0;
        i_valid = 1'b0;
        #1;
        check("async_rst_red", 32'(o_red_gain), 32'd4);
        check("async_rst_blue", 32'(o_blue_gain), 32'd4);
        check("async_rst_green", 32'(o_green_gain), 32'd4);
        check("async_rst_stat", 32'(o_stat_valid), 32'd0);
        check("async_rst_err", 32'(o_frame_err), 32'd0);
        @(negedge i_pclk);
        @(negedge i_pclk);
        i_arstn = 1'b1;
        idle(2);
        do_fs(1'b0, 1'b1, 3'd4, 3'd4);
        idle(6);
        drive_frame(256, 512, 512, 4);
        do_fs(1'b0, 1'b0, 3'd5, 3'd4);
        idle(6);

        // Bounded drain of outstanding expectations
        for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge i_pclk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
